ctrl_packer_avlstrm: RTL and testbench
======================================

# ctrl_packer_avlstrm

Host-side control register writer that serializes register updates onto an Avalon-ST link as single-beat `stats_t` packets. It is the transmitting counterpart of the stats unpacker and travels in the opposite direction: host configuration writes flow toward remote modules. Each write is buffered in a small FIFO and mirrored into a local shadow file for readback. Backpressure is applied to the host through `waitrequest`.

## Interface
Parameters:
- `NUM_REG`, 64: number of shadow registers. Writes to addresses `>= NUM_REG` are dropped.
- `FIFO_DEPTH`, 8: write queue depth. Must be a power of 2 and at least 2.
- `REFRESH_INTERVAL`, 4096: cycles between periodic re-broadcasts. Used only with `CTRL_REFRESH_EN`.

Ports:
- `Clk`, in, 1: single clock.
- `Rst`, in, 1: synchronous, active-high reset.
- `write`, in, 1: host write strobe.
- `writeaddr`, in, 8: register address.
- `writedata`, in, 32: register value.
- `waitrequest`, out, 1: write not accepted this cycle.
- `readaddr`, in, 8: shadow readback address.
- `readdata`, out, 32: shadow value. Combinational. Returns 0 for `readaddr >= NUM_REG`.
- `ctrl_out`, `avl_stream_if.tx`: carries `stats_t{addr, val}`; uses valid, ready, sop, eop and data.

## Operation
- A write is accepted when `write && !waitrequest`.
  - In-range addresses: the shadow entry is updated and the `{addr, val}` entry is pushed to the FIFO.
  - Out-of-range addresses: the write is accepted and discarded. No shadow update, no push.
- `waitrequest = (count == FIFO_DEPTH)`. A push is never accepted while full, even if a pop happens in the same cycle.
- The FIFO is first-word-fall-through:
  - `ctrl_out.valid = (count != 0)`, or a refresh beat is active (see Configuration).
  - `sop = eop = valid`.
  - `data` = head entry.
- A pop occurs on `valid && ready`.
- Same-order guarantee: beats are emitted in write-acceptance order. Repeated writes to the same address are all emitted; they are never coalesced.
- Simultaneous push and pop with `0 < count < FIFO_DEPTH`: count is unchanged and both operations take effect.
- Pointers wrap modulo `FIFO_DEPTH`. `count` is `$clog2(FIFO_DEPTH)+1` bits wide.

## Timing
- Reset values:
  - `count = 0`, both pointers at 0, all shadow entries 0.
  - `waitrequest = 0`, `ctrl_out.valid = 0`, `sop = eop = 0`.
  - Refresh FSM in `IDLE`, interval counter at 0.
- Write-to-stream latency: a write accepted in cycle N into an empty FIFO gives `valid = 1` in cycle N+1.
- Write-to-readback latency: `readdata` reflects the new value from cycle N+1.
- `valid` and `data` stay stable while `valid && !ready`. A presented beat is never withdrawn or replaced.
- Throughput is one beat per cycle with `ready` held high.
- Reset asserted mid-transfer discards all queued entries. No beat is emitted in the cycle after `Rst` deasserts.

## Configuration
- Macro: `CTRL_REFRESH_EN`.
- Defined: periodic refresh re-broadcasts the whole shadow file so that remote state survives remote resets.
  - An interval counter counts from 0 to `REFRESH_INTERVAL-1` while the FSM is in `IDLE`, then enters `SWEEP` with `idx = 0`.
  - In `SWEEP`, host-write FIFO beats have priority. A refresh beat `{idx, shadow[idx]}` is presented only when `count == 0`.
  - Once a refresh beat is presented it is locked until accepted, even if the FIFO becomes non-empty.
  - On acceptance, `idx` increments. After `idx = NUM_REG-1` is accepted, the FSM returns to `IDLE` and the counter restarts at 0.
  - The counter is held at 0 during `SWEEP`.
  - Shadow updates during `SWEEP` are visible to not-yet-sent indices.
- Undefined: no counter and no FSM. Only host writes are emitted, and `valid = (count != 0)`.

## Test plan
- Reset then idle for 100 cycles -> `valid = 0`, `waitrequest = 0`, `readdata(0..NUM_REG-1) = 0`.
- Write `addr 5 = 0xDEADBEEF` with `ready = 1` -> one beat `{5, 0xDEADBEEF}`, sop = eop = 1, one cycle after acceptance; `readdata(5) = 0xDEADBEEF` next cycle.
- Hold `ready = 0` and issue 10 writes to `addr 0..9` -> `waitrequest` asserts after 8 accepted writes. Then raise `ready` -> beats `0..7` in order with stable data under stall, followed by the remaining 2 writes once accepted.
- Write `addr = NUM_REG` (64) with value `0x1` -> accepted (`waitrequest = 0`), no beat, `readdata(64) = 0`.
- Assert `Rst` with 4 entries queued and `ready = 0` -> after reset, `valid = 0` and `count = 0`; a new write emits only the new entry.
- With `CTRL_REFRESH_EN`, `REFRESH_INTERVAL = 16` and `NUM_REG = 4` after writing `reg 2 = 7` -> after 16 idle cycles, beats `{0,0}, {1,0}, {2,7}, {3,0}`. A host write issued mid-sweep is emitted before the next unsent refresh beat.

Source files
------------

// File: rtl/ctrl_packer_avlstrm_if.sv
// Avalon-ST link bundle used by ctrl_packer_avlstrm.
// valid/ready: a beat transfers on a cycle where valid && ready are both high;
// once valid is raised, valid and data hold until that transfer happens.
interface avl_stream_if #(
    parameter int DATA_W = 40
);
    logic              valid;
    logic              ready;
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;

    modport tx (output valid, output sop, output eop, output data, input ready);
    modport rx (input valid, input sop, input eop, input data, output ready);
endinterface

// File: rtl/ctrl_packer_avlstrm.sv
// ctrl_packer_avlstrm: host control-register writer.
// Each accepted in-range write updates a local shadow file and is queued in a
// first-word-fall-through FIFO. Each queued entry leaves as a single-beat
// {addr, val} packet on ctrl_out. Host backpressure is applied via waitrequest.
//
// Optional feature, macro CTRL_REFRESH_EN: a periodic sweep re-broadcasts the
// whole shadow file. Host FIFO beats take priority over refresh beats. Once a
// refresh beat is shown, it is locked until it is accepted.
//
// Handshake: a beat transfers on a cycle where ctrl_out.valid && ctrl_out.ready
// are both high. While valid && !ready, valid and data do not change.
module ctrl_packer_avlstrm #(
    parameter int NUM_REG          = 64,
    parameter int FIFO_DEPTH       = 8,
    parameter int REFRESH_INTERVAL = 4096
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          write,
    input  logic [7:0]    writeaddr,
    input  logic [31:0]   writedata,
    output logic          waitrequest,
    input  logic [7:0]    readaddr,
    output logic [31:0]   readdata,
    output logic          dbg_state,
    avl_stream_if.tx      ctrl_out
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int RAW = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
    localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] val;
    } stats_t;

    // Storage
    logic [31:0]   r_shadow [NUM_REG];
    stats_t        r_fifo   [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    // Host side
    logic   w_wr_in_range;
    logic   w_rd_in_range;
    logic   w_accept;
    logic   w_push;
    logic   w_pop;
    logic   w_fifo_nonempty;
    stats_t w_head;

    // Refresh selection (tied off when the feature is not built)
    logic   w_ref_valid;
    stats_t w_ref_beat;

    assign w_wr_in_range   = ({24'd0, writeaddr} < 32'(NUM_REG));
    assign w_rd_in_range   = ({24'd0, readaddr} < 32'(NUM_REG));
    assign waitrequest     = (r_count == CNT_FULL);
    assign w_accept        = write && !waitrequest;
    assign w_push          = w_accept && w_wr_in_range;
    assign w_fifo_nonempty = (r_count != '0);
    assign w_head          = r_fifo[r_rd_ptr];

    // A FIFO beat pops only when it is the one being presented.
    assign w_pop = ctrl_out.ready && w_fifo_nonempty && !w_ref_valid;

    assign readdata = w_rd_in_range ? r_shadow[readaddr[RAW-1:0]] : 32'd0;

    // Stream output: a refresh beat, when shown, overrides the FIFO head.
    assign ctrl_out.valid = w_ref_valid || w_fifo_nonempty;
    assign ctrl_out.sop   = ctrl_out.valid;
    assign ctrl_out.eop   = ctrl_out.valid;
    assign ctrl_out.data  = w_ref_valid ? w_ref_beat : w_head;

    // Shadow register file: mirrors every accepted in-range write
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REG; i++) begin
                r_shadow[i] <= 32'd0;
            end
        end else if (w_push) begin
            r_shadow[writeaddr[RAW-1:0]] <= writedata;
        end
    end

    // FIFO payload storage; its contents are irrelevant until count says so
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{addr: writeaddr, val: writedata};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef CTRL_REFRESH_EN
    localparam int CW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CW-1:0]  T_LAST   = CW'(REFRESH_INTERVAL - 1);
    localparam logic [RAW-1:0] IDX_LAST = RAW'(NUM_REG - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } ref_state_t;

    ref_state_t     r_state;
    logic [CW-1:0]  r_timer;
    logic [RAW-1:0] r_idx;
    logic           r_lock;
    stats_t         r_lock_beat;
    logic           w_ref_accept;

    // A refresh beat appears when the FIFO is empty. Once shown, it stays
    // (locked) even if host writes arrive.
    assign w_ref_valid  = (r_state == ST_SWEEP) && (r_lock || !w_fifo_nonempty);
    assign w_ref_beat   = r_lock ? r_lock_beat : {8'(r_idx), r_shadow[r_idx]};
    assign w_ref_accept = w_ref_valid && ctrl_out.ready;
    assign dbg_state    = (r_state == ST_SWEEP);

    // Refresh FSM: count the idle interval, then sweep every shadow index once
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_idx       <= '0;
            r_lock      <= 1'b0;
            r_lock_beat <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_timer == T_LAST) begin
                        r_state <= ST_SWEEP;
                        r_timer <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_SWEEP: begin
                    r_timer <= '0;
                    if (w_ref_accept) begin
                        r_lock <= 1'b0;
                        if (r_idx == IDX_LAST) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else if (w_ref_valid && !r_lock) begin
                        // Freeze the shown value so a later shadow write
                        // cannot change a beat that is already on the link.
                        r_lock      <= 1'b1;
                        r_lock_beat <= w_ref_beat;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
`else
    assign w_ref_valid = 1'b0;
    assign w_ref_beat  = '0;
    assign dbg_state   = 1'b0;
`endif

    // A stalled beat must still be shown next cycle with identical data
    a_stall_stable: assert property (@(posedge Clk) disable iff (Rst)
        (ctrl_out.valid && !ctrl_out.ready) |=> (ctrl_out.valid && $stable(ctrl_out.data)));

endmodule

// File: tb/tb_ctrl_packer_avlstrm.sv
// Bench for ctrl_packer_avlstrm. A queue-based model of the link is checked
// every cycle: which beats must appear, their order, backpressure, and readback.
module tb_ctrl_packer_avlstrm;

`ifdef CTRL_REFRESH_EN
    localparam int NUM_REG  = 4;
    localparam int INTERVAL = 16;
`else
    localparam int NUM_REG  = 64;
    localparam int INTERVAL = 4096;
`endif
    localparam int DEPTH = 8;

    // ---------------- clock / reset / DUT ----------------
    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        write     = 1'b0;
    logic [7:0]  writeaddr = 8'd0;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  readaddr  = 8'd0;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        dbg_state;

    avl_stream_if ctrl_if ();

    always #5 clk = ~clk;

    ctrl_packer_avlstrm #(
        .NUM_REG          (NUM_REG),
        .FIFO_DEPTH       (DEPTH),
        .REFRESH_INTERVAL (INTERVAL)
    ) dut (
        .Clk         (clk),
        .Rst         (rst),
        .write       (write),
        .writeaddr   (writeaddr),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readaddr    (readaddr),
        .readdata    (readdata),
        .dbg_state   (dbg_state),
        .ctrl_out    (ctrl_if)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [39:0] exp_q[$];
    logic [31:0] m_shadow [NUM_REG];
    logic        m_sweep    = 1'b0;
    int          m_timer    = 0;
    int          m_idx      = 0;
    logic        m_lock     = 1'b0;
    logic [39:0] m_lock_val = '0;

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < NUM_REG; i++) m_shadow[i] = 32'd0;
        m_sweep = 1'b0;
        m_timer = 0;
        m_idx   = 0;
        m_lock  = 1'b0;
    endtask

    // Scoreboard: at each negedge compare outputs with the model, then advance
    // the model by what the coming posedge will do.
    always @(negedge clk) begin : scoreboard
        logic        ref_pres;
        logic        exp_valid;
        logic        was_full;
        logic        was_sweep;
        logic [39:0] exp_data;
        logic [31:0] exp_rd;
        if (rst) begin
            model_reset();
        end else begin
            was_full  = (exp_q.size() == DEPTH);
            was_sweep = m_sweep;
            ref_pres  = m_sweep && (m_lock || exp_q.size() == 0);
            exp_valid = ref_pres || (exp_q.size() != 0);
            if (ref_pres)
                exp_data = m_lock ? m_lock_val : {8'(m_idx), m_shadow[m_idx]};
            else if (exp_q.size() != 0)
                exp_data = exp_q[0];
            else
                exp_data = '0;
            exp_rd = (int'(readaddr) < NUM_REG) ? m_shadow[readaddr] : 32'd0;

            chk("valid", ctrl_if.valid, exp_valid);
            chk("sop", ctrl_if.sop, exp_valid);
            chk("eop", ctrl_if.eop, exp_valid);
            if (exp_valid) chk("data", ctrl_if.data, exp_data);
            chk("waitrequest", waitrequest, was_full);
            chk("readdata", readdata, exp_rd);
            chk("dbg_state", dbg_state, m_sweep);

            // stream side
            if (exp_valid && ctrl_if.ready) begin
                if (ref_pres) begin
                    m_lock = 1'b0;
                    if (m_idx == NUM_REG - 1) begin
                        m_sweep = 1'b0;
                        m_timer = 0;
                    end else begin
                        m_idx++;
                    end
                end else begin
                    void'(exp_q.pop_front());
                end
            end else if (ref_pres && !m_lock) begin
                m_lock     = 1'b1;
                m_lock_val = exp_data;
            end

`ifdef CTRL_REFRESH_EN
            // refresh interval
            if (!was_sweep) begin
                if (m_timer == INTERVAL - 1) begin
                    m_sweep = 1'b1;
                    m_idx   = 0;
                    m_timer = 0;
                end else begin
                    m_timer++;
                end
            end
`endif

            // host side
            if (write && !was_full && int'(writeaddr) < NUM_REG) begin
                exp_q.push_back({writeaddr, writedata});
                m_shadow[writeaddr] = writedata;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [31:0] d);
        int n;
        write     = 1'b1;
        writeaddr = a;
        writedata = d;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (!waitrequest) break;
            n++;
        end
        if (n >= 50) chk("write_timeout", waitrequest, 1'b0);
        tick();
        write = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        write = 1'b0;
        rst   = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ctrl_if.ready = 1'b0;
        tick();
        do_reset(3);

        // idle after reset, sweep readback across all shadow entries
        for (int i = 0; i < 100; i++) begin
            readaddr = 8'(i % NUM_REG);
            tick();
        end

        // single write, ready high
        ctrl_if.ready = 1'b1;
        host_write(8'd5 % 8'(NUM_REG), 32'hDEAD_BEEF);
        readaddr = 8'd5 % 8'(NUM_REG);
        repeat (3) tick();

        // fill under stall, then release
        ctrl_if.ready = 1'b0;
        for (int i = 0; i < 8; i++) host_write(8'(i % NUM_REG), 32'h100 + 32'(i));
        fork
            begin
                host_write(8'(8 % NUM_REG), 32'h108);
                host_write(8'(9 % NUM_REG), 32'h109);
            end
            begin
                repeat (6) tick();
                ctrl_if.ready = 1'b1;
            end
        join
        repeat (20) tick();

        // out-of-range write is accepted and dropped
        host_write(8'(NUM_REG), 32'h1);
        readaddr = 8'(NUM_REG);
        repeat (3) tick();

        // reset with entries queued
        ctrl_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) host_write(8'(i), 32'hA0 + 32'(i));
        do_reset(2);
        repeat (3) tick();
        ctrl_if.ready = 1'b1;
        host_write(8'd3, 32'h0000_CAFE);
        readaddr = 8'd3;
        repeat (5) tick();

`ifdef CTRL_REFRESH_EN
        // sweep after an idle interval, then a host write in mid-sweep
        do_reset(2);
        ctrl_if.ready = 1'b1;
        host_write(8'd2, 32'd7);
        repeat (INTERVAL + 10) tick();
        begin : wait_sweep
            int n;
            n = 0;
            while (!m_sweep && n < 4 * INTERVAL) begin
                tick();
                n++;
            end
            chk("sweep_start", dbg_state, 1'b1);
        end
        ctrl_if.ready = 1'b0;
        tick();
        host_write(8'd1, 32'h55);
        ctrl_if.ready = 1'b1;
        repeat (20) tick();
`endif

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            write         = ($urandom_range(0, 1) == 1);
            writeaddr     = 8'($urandom_range(0, NUM_REG + 6));
            writedata     = $urandom;
            ctrl_if.ready = ($urandom_range(0, 9) < 7);
            readaddr      = 8'($urandom_range(0, NUM_REG + 6));
            tick();
        end
        write         = 1'b0;
        ctrl_if.ready = 1'b1;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
